// File: rtl/mac_mult_pkg.sv
// Shared definitions for the iterative CMAC multiplier: state encoding,
// slice width and the operand-width legality rule.
package mac_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int SLICE_W = 8;

    function automatic bit data_w_legal(input int w);
        return ((w % SLICE_W) == 0) && (w >= SLICE_W) && (w <= 32);
    endfunction

endpackage

// File: rtl/mac_mult_chk.sv
// Elaboration-time guard: stops the build when the operand width cannot be
// sliced into whole 8-bit pieces or exceeds the supported 32 bits.
module mac_mult_chk
    import mac_mult_pkg::*;
#(
    parameter int DATA_W = 16
) ();

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $fatal(1, "mac_mult_iter: DATA_W=%0d must be a multiple of 8 in 8..32", DATA_W);
    end

endmodule

// File: rtl/mult_slice8.sv
// Shared 8x8 unsigned slice multiplier; kept as its own module so a
// hand-mapped array can be dropped in without touching the control logic.
module mult_slice8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    assign p = {8'd0, a} * {8'd0, b};

endmodule

// File: rtl/mac_mult_iter.sv
// Iterative signed/unsigned multiplier: magnitudes are multiplied one 8x8
// slice pair per cycle into a shifted accumulator, then sign-corrected.
module mac_mult_iter
    import mac_mult_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_prod,
    output logic                  busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [DATA_W-1:0]    a_mag_r;
    logic [DATA_W-1:0]    b_mag_r;
    logic [DATA_W-1:0]    a_mag_s;
    logic [DATA_W-1:0]    b_mag_s;
    logic                 neg_r;
    logic                 neg_s;
    logic [PROD_W-1:0]    acc_r;
    logic [PROD_W-1:0]    prod_r;
    logic [PROD_W-1:0]    pp_shift_s;
    logic [IDX_W-1:0]     i_r;
    logic [IDX_W-1:0]     j_r;
    logic [7:0]           a_slices_s [NSLICE];
    logic [7:0]           b_slices_s [NSLICE];
    logic [7:0]           a_sl_s;
    logic [7:0]           b_sl_s;
    logic [15:0]          pp_s;
    logic [IDX_W+3:0]     shamt_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 last_s;

    mac_mult_chk #(.DATA_W(DATA_W)) u_chk ();

    // Operand acceptance: idle, or done while the product is being taken.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_DONE: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid & in_ready_s;
    assign last_s   = (i_r == LAST_IDX) && (j_r == LAST_IDX);

    // Operand magnitudes and result sign; the most negative value maps to 2^(DATA_W-1).
    always_comb begin
        a_mag_s = in_a;
        b_mag_s = in_b;
        if (in_signed && in_a[DATA_W-1]) begin
            a_mag_s = ~in_a + DATA_W'(1);
        end else begin
            a_mag_s = in_a;
        end
        if (in_signed && in_b[DATA_W-1]) begin
            b_mag_s = ~in_b + DATA_W'(1);
        end else begin
            b_mag_s = in_b;
        end
        neg_s = in_signed & (in_a[DATA_W-1] ^ in_b[DATA_W-1]);
    end

    for (genvar k = 0; k < NSLICE; k++) begin : g_slices
        assign a_slices_s[k] = a_mag_r[k*SLICE_W +: SLICE_W];
        assign b_slices_s[k] = b_mag_r[k*SLICE_W +: SLICE_W];
    end

    assign a_sl_s = a_slices_s[i_r];
    assign b_sl_s = b_slices_s[j_r];

    mult_slice8 u_slice (
        .a (a_sl_s),
        .b (b_sl_s),
        .p (pp_s)
    );

    assign shamt_s    = {({1'b0, i_r} + {1'b0, j_r}), 3'b000};
    assign pp_shift_s = PROD_W'(pp_s) << shamt_s;

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_s) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_FIX: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    state_nxt_s = ST_MUL;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, slice counters, accumulator and product register.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            a_mag_r <= '0;
            b_mag_r <= '0;
            neg_r   <= 1'b0;
            acc_r   <= '0;
            i_r     <= '0;
            j_r     <= '0;
            prod_r  <= '0;
        end else begin
            if (accept_s) begin
                a_mag_r <= a_mag_s;
                b_mag_r <= b_mag_s;
                neg_r   <= neg_s;
                acc_r   <= '0;
                i_r     <= '0;
                j_r     <= '0;
            end else if (state_r == ST_MUL) begin
                acc_r <= acc_r + pp_shift_s;
                if (j_r == LAST_IDX) begin
                    j_r <= '0;
                    i_r <= i_r + IDX_W'(1);
                end else begin
                    j_r <= j_r + IDX_W'(1);
                end
            end
            // ~0 + 1 wraps to 0, so a zero product never carries a stray sign bit.
            if (state_r == ST_FIX) begin
                prod_r <= neg_r ? (~acc_r + PROD_W'(1)) : acc_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign out_prod  = prod_r;

endmodule

// File: tb/tb_mac_mult_iter.sv
// Self-checking bench for mac_mult_iter at DATA_W=16 and DATA_W=32, using
// directed cases and a randomized sweep against an arithmetic reference.
module tb_mac_mult_iter;

    logic        clk;
    logic        rst;

    logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, busy16;
    logic [15:0] in_a16, in_b16;
    logic [31:0] out_prod16;

    logic        in_valid32, in_ready32, in_signed32, out_valid32, out_ready32, busy32;
    logic [31:0] in_a32, in_b32;
    logic [63:0] out_prod32;

    int tests = 0;
    int fails = 0;

    mac_mult_iter #(.DATA_W(16)) u16 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_valid       (in_valid16),
        .in_ready       (in_ready16),
        .in_a           (in_a16),
        .in_b           (in_b16),
        .in_signed      (in_signed16),
        .out_valid      (out_valid16),
        .out_ready      (out_ready16),
        .out_prod       (out_prod16),
        .busy           (busy16)
    );

    mac_mult_iter #(.DATA_W(32)) u32 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_valid       (in_valid32),
        .in_ready       (in_ready32),
        .in_a           (in_a32),
        .in_b           (in_b32),
        .in_signed      (in_signed32),
        .out_valid      (out_valid32),
        .out_ready      (out_ready32),
        .out_prod       (out_prod32),
        .busy           (busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product of the operands read as w-bit values.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input int w);
        logic signed [65:0] ea, eb, p;
        logic [65:0]        mask;
        ea = $signed({34'd0, a});
        eb = $signed({34'd0, b});
        if (sgn && a[w-1]) ea = ea - (66'sd1 <<< w);
        if (sgn && b[w-1]) eb = eb - (66'sd1 <<< w);
        p    = ea * eb;
        mask = (66'd1 << (2 * w)) - 66'd1;
        return 64'(p & $signed(mask));
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Presents one operand pair for a single edge; caller guarantees in_ready.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        in_a16 = a; in_b16 = b; in_signed16 = sgn; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic wait16(input string tag, input logic [31:0] exp);
        int cyc = 0;
        while (!out_valid16 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd5);
        chk(tag, 64'(out_prod16), 64'(exp));
    endtask

    task automatic release16();
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("rel16_valid", 64'(out_valid16), 64'd0);
    endtask

    task automatic mul16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input logic [31:0] exp);
        start16(a, b, sgn);
        wait16(tag, exp);
        release16();
    endtask

    task automatic mul32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp);
        int cyc = 0;
        in_a32 = a; in_b32 = b; in_signed32 = sgn; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        while (!out_valid32 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd17);
        chk(tag, out_prod32, exp);
        out_ready32 = 1'b1;
        @(posedge clk); #1;
        out_ready32 = 1'b0;
    endtask

    initial begin
        logic [15:0] a16, b16;
        logic [31:0] a32, b32;
        logic        s;
        logic [31:0] exp16;
        logic [31:0] held;

        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; in_a32 = '0; in_b32 = '0; in_signed32 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready16), 64'd1);
        chk("rst_out_valid", 64'(out_valid16), 64'd0);
        chk("rst_busy", 64'(busy16), 64'd0);
        chk("rst_out_prod", 64'(out_prod16), 64'd0);
        chk("rst_out_prod32", out_prod32, 64'd0);
        chk("rst_in_ready32", 64'(in_ready32), 64'd1);

        mul16("neg3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
        mul16("min_x_min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        mul16("min_x_1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000);
        mul16("zero_neg", 16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000);
        mul16("ffff_uns", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        mul16("ffff_sgn", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);

        // Backpressure in DONE, then a same-cycle handoff to new operands.
        start16(16'h1234, 16'h5678, 1'b0);
        wait16("bp_first", 32'h0626_0060);
        held = out_prod16;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("bp_prod_stable", 64'(out_prod16), 64'(held));
            chk("bp_valid_held", 64'(out_valid16), 64'd1);
            chk("bp_in_ready", 64'(in_ready16), 64'd0);
        end
        out_ready16 = 1'b1;
        start16(16'h0002, 16'h0003, 1'b0);
        out_ready16 = 1'b0;
        chk("b2b_busy", 64'(busy16), 64'd1);
        chk("b2b_valid_low", 64'(out_valid16), 64'd0);
        wait16("b2b_6", 32'h0000_0006);
        release16();

        // Reset during the second MUL cycle discards the operation.
        start16(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(busy16), 64'd0);
        chk("mrst_valid", 64'(out_valid16), 64'd0);
        chk("mrst_prod", 64'(out_prod16), 64'd0);
        chk("mrst_ready", 64'(in_ready16), 64'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("mrst_no_result", 64'(out_valid16), 64'd0);
        mul16("after_rst", 16'h0007, 16'hFFFF, 1'b1, 32'hFFFF_FFF9);

        mul32("w32_dir", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001);
        mul32("w32_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        mul32("w32_uns", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);

        // Random 16-bit sweep with random stalls and back-to-back handoffs.
        a16 = pick16(); b16 = pick16(); s = 1'($urandom);
        exp16 = 32'(ref_mul({16'd0, a16}, {16'd0, b16}, s, 16));
        start16(a16, b16, s);
        for (int n = 0; n < 5000; n++) begin
            wait16("rnd16", exp16);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            chk("rnd16_hold", 64'(out_prod16), 64'(exp16));
            a16 = pick16(); b16 = pick16(); s = 1'($urandom);
            exp16 = 32'(ref_mul({16'd0, a16}, {16'd0, b16}, s, 16));
            if ($urandom_range(0, 1) == 1) begin
                out_ready16 = 1'b1;
                start16(a16, b16, s);
                out_ready16 = 1'b0;
            end else begin
                release16();
                start16(a16, b16, s);
            end
        end
        wait16("rnd16_last", exp16);
        release16();

        for (int n = 0; n < 600; n++) begin
            a32 = pick32(); b32 = pick32(); s = 1'($urandom);
            mul32("rnd32", a32, b32, s, ref_mul(a32, b32, s, 32));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
